frame_crc_parser: RTL and testbench
===================================

# frame_crc_parser

Input-side frame parser with an integrated word-parallel CRC-16 checker, running in the `clk_in` domain. It hunts for frames on a free-running 16-bit word stream and unpacks the control and payload words. It checks each frame's CRC and presents verified frames as a single 140-bit word with a one-cycle write strobe. The write strobe and 140-bit word drive the asynchronous FIFO that feeds the gray-code/serial output path.

## Interface
Parameters:
- `HEADER`, 16'hE0E0, frame start word.
- `MAX_WORDS`, 8, maximum payload words per frame.

Ports:
- `clk_in`  input  1  system clock; the block's only clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `data_in`  input  16  input word stream, one word sampled per `clk_in` rising edge.
- `data_to_fifo`  output  140  frame word, packed as {vld_ch[7:0], len[3:0], payload[127:0]}.
- `fifo_w_enable`  output  1  one-cycle write strobe for `data_to_fifo`.
- `crc_err`  output  1  one-cycle pulse when a frame fails its CRC check.
- `crc_valid_o`  output  1  one-cycle pulse when a frame passes its CRC check.

## Operation
- Frame format, in word order:
  - `HEADER`
  - control word: [15:8] vld_ch, [7:4] reserved, [3:0] len
  - len payload words
  - CRC word
- CRC algorithm: CRC-16/CCITT-FALSE.
  - Polynomial 0x1021, init 0xFFFF.
  - MSB first, no reflection, no final XOR.
  - Computed over the payload words only.
  - One full 16-bit word is folded per cycle by unrolled combinational logic.
- State machine:
  - IDLE: a word equal to `HEADER` moves to CTRL; any other word is discarded.
  - CTRL:
    - If len is 1..8: latch vld_ch and len, clear the payload register, load CRC = 0xFFFF, go to PAYLOAD.
    - If len is 0 or greater than 8: return to IDLE with no output and no error pulse.
  - PAYLOAD:
    - Word k (0-based) is stored at payload[127-16k -: 16] and folded into the CRC.
    - After the len-th word, go to CHECK.
    - Unfilled payload words stay 0.
  - CHECK:
    - Compare `data_in` with the accumulated CRC, then return to IDLE.
    - Match: pulse `fifo_w_enable` and `crc_valid_o`.
    - Mismatch: pulse `crc_err`.
- Inside a frame, a word equal to `HEADER` is treated as ordinary data; there is no resynchronisation.
- `data_to_fifo` holds its value between writes.
- Full-flag back-pressure is out of scope. The FIFO drops writes when it is full.

## Timing
- Reset values: state IDLE; `data_to_fifo` = 0; `fifo_w_enable` = 0; `crc_err` = 0; `crc_valid_o` = 0; CRC register = 0xFFFF.
- Let the CRC word be sampled at edge T. Then:
  - The strobe or error pulse is high from T to T+1.
  - `data_to_fifo` is updated at edge T, i.e. it is valid while `fifo_w_enable` is high.
- Frame latency: header at cycle 0 gives the output pulse at cycle len+3.
- Back-to-back frames: a header sampled at edge T+1 is accepted, with zero idle words between frames.
- Reset asserted mid-frame: the partial frame is abandoned and no pulse is emitted. After release the block hunts for a header.
- All outputs are registered. `crc_err` and `crc_valid_o` are never high in the same cycle.

## Configuration
- `FRAME_CRC_CHECK_EN` defined:
  - Behaviour is as described above.
  - Failing frames are not written.
- `FRAME_CRC_CHECK_EN` undefined:
  - The CRC logic is removed and the CRC word is consumed but ignored.
  - Every well-formed frame is written with `crc_valid_o` pulsed.
  - `crc_err` is tied to 0.

## Test plan
- Good single-word frame: E0E0, 0101, 0000, 1D0F -> one `fifo_w_enable` pulse at cycle 4 and one `crc_valid_o` pulse. `data_to_fifo` = {8'h01, 4'h1, 128'h0}.
- Bad CRC: E0E0, 0101, 0000, 1D0E -> one `crc_err` pulse, no write, `data_to_fifo` unchanged.
- Invalid length: E0E0, 0A00 (len 0) and E0E0, 0109 (len 9) -> no pulses at all. A following valid frame is accepted.
- Back-to-back: two good single-word frames with no gap -> two write pulses 4 cycles apart. Noise words (1234, FFFF) before the first header are ignored.
- Reset mid-payload: len 8, rst_n pulsed after 3 payload words -> no pulses, all outputs 0. The next good frame is written.
- Full-length frame: len 8, all-zero payload, correct CRC -> `data_to_fifo` = {vld_ch, 4'h8, 128'h0}. Also check the `FRAME_CRC_CHECK_EN`-undefined build writes a frame carrying a wrong CRC.

Source files
------------

// File: rtl/frame_crc_parser.sv
// frame_crc_parser: hunts HEADER-led frames on a 16-bit stream, unpacks them and writes them to a FIFO.
// Define FRAME_CRC_CHECK_EN to verify each frame's CRC-16/CCITT-FALSE; otherwise the CRC word is ignored.
module frame_crc_parser #(
  parameter logic [15:0] HEADER = 16'hE0E0,
  parameter int MAX_WORDS = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic [15:0]  data_in,
  output logic [139:0] data_to_fifo,
  output logic         fifo_w_enable,
  output logic         crc_err,
  output logic         crc_valid_o
);
  typedef enum logic [1:0] {IDLE, CTRL, PAYLOAD, CHECK} state_t;
  state_t state;
  logic [7:0] vld_ch;
  logic [3:0] len;
  logic [2:0] cnt;
  logic [127:0] payload;
  logic match;
  logic len_ok;
  assign len_ok = data_in[3:0] != 4'd0 && data_in[3:0] <= 4'(MAX_WORDS);
`ifdef FRAME_CRC_CHECK_EN
  logic [15:0] crc;
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  assign match = data_in == crc;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) crc <= 16'hFFFF;
    else if (state == CTRL) crc <= 16'hFFFF;
    else if (state == PAYLOAD) crc <= crc_fold(crc, data_in);
`else
  assign match = 1'b1;
`endif
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vld_ch        <= 8'd0;
      len           <= 4'd0;
      cnt           <= 3'd0;
      payload       <= 128'd0;
      data_to_fifo  <= 140'd0;
      fifo_w_enable <= 1'b0;
      crc_err       <= 1'b0;
      crc_valid_o   <= 1'b0;
    end else begin
      fifo_w_enable <= 1'b0;
      crc_err       <= 1'b0;
      crc_valid_o   <= 1'b0;
      case (state)
        IDLE: if (data_in == HEADER) state <= CTRL;
        CTRL: begin
          state   <= len_ok ? PAYLOAD : IDLE;
          vld_ch  <= data_in[15:8];
          len     <= data_in[3:0];
          cnt     <= 3'd0;
          payload <= 128'd0;
        end
        PAYLOAD: begin
          // word k lands at payload[127-16k -: 16]; ~cnt is 7-cnt
          payload[{~cnt, 4'b0} +: 16] <= data_in;
          cnt <= cnt + 3'd1;
          if ({1'b0, cnt} == len - 4'd1) state <= CHECK;
        end
        CHECK: begin
          state         <= IDLE;
          fifo_w_enable <= match;
          crc_valid_o   <= match;
          crc_err       <= ~match;
          if (match) data_to_fifo <= {vld_ch, len, payload};
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_crc_parser.sv
// tb_frame_crc_parser: table-driven frames plus hand-written corner cases, checked through a pulse scoreboard.
module tb_frame_crc_parser;
`ifdef FRAME_CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [139:0] data_to_fifo;
  logic fifo_w_enable, crc_err, crc_valid_o;
  int cyc = 0;
  int total = 0;
  int pass_cnt = 0;
  logic [139:0] last_written = 140'd0;

  typedef struct {
    logic err;
    int cyc;
    logic [139:0] data;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0] vld;
    logic [3:0] len;
    logic [127:0] words;
    logic [15:0] crc_xor;
    logic exp_err;
    logic [139:0] exp_data;
  } frame_t;
  frame_t tbl[6];

  frame_crc_parser dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .data_to_fifo(data_to_fifo),
    .fifo_w_enable(fifo_w_enable), .crc_err(crc_err), .crc_valid_o(crc_valid_o)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [15:0] crc_ref(input logic [127:0] words, input int n);
    logic [15:0] c, w;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      w = words[127-16*k -: 16];
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ w[b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic send(input logic [15:0] w);
    data_in = w;
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic err, input int c, input logic [139:0] d);
    exp_t e;
    e.err = err; e.cyc = c; e.data = d;
    q.push_back(e);
  endtask

  // header edge index h: pulse is registered at the CRC edge h+len+2
  task automatic send_frame(input frame_t f);
    int h;
    send(16'hE0E0);
    h = cyc;
    send({f.vld, 4'h0, f.len});
    for (int k = 0; k < int'(f.len); k++) send(f.words[127-16*k -: 16]);
    send(crc_ref(f.words, int'(f.len)) ^ f.crc_xor);
    push(f.exp_err, h + int'(f.len) + 2, f.exp_data);
  endtask

  task automatic send_literal4(input logic [15:0] c, input logic err, input logic [139:0] d);
    int h;
    send(16'hE0E0);
    h = cyc;
    send(16'h0101);
    send(16'h0000);
    send(c);
    push(err, h + 3, d);
  endtask

  always @(negedge clk_in) begin
    if (fifo_w_enable || crc_err || crc_valid_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse cycle=%0d wr=%b err=%b valid=%b required=none",
                 cyc, fifo_w_enable, crc_err, crc_valid_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", 140'(cyc), 140'(e.cyc));
        chk("crc_err", 140'(crc_err), 140'(e.err));
        chk("crc_valid_o", 140'(crc_valid_o), 140'(!e.err));
        chk("fifo_w_enable", 140'(fifo_w_enable), 140'(!e.err));
        chk("data_to_fifo", data_to_fifo, e.err ? last_written : e.data);
        if (!e.err) last_written = e.data;
      end
    end
  end

  initial begin
    tbl[0] = '{8'h5A, 4'd3, {16'h1234, 16'hABCD, 16'hE0E0, 80'h0}, 16'h0, 1'b0, 140'h0};
    tbl[1] = '{8'h3C, 4'd8, {16'hFFFF, 16'h0001, 16'h8000, 16'hE0E0, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0}, 16'h0, 1'b0, 140'h0};
    tbl[2] = '{8'h12, 4'd2, {16'hDEAD, 16'hBEEF, 96'h0}, 16'h0, 1'b0, 140'h0};
    tbl[3] = '{8'hFF, 4'd8, 128'h0, 16'h0, 1'b0, 140'h0};
    tbl[4] = '{8'h77, 4'd8, 128'h0, 16'h0100, 1'b0, 140'h0};
    tbl[5] = '{8'hC3, 4'd5, {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 48'h0}, 16'h0, 1'b0, 140'h0};
    foreach (tbl[i]) begin
      logic [127:0] mask;
      mask = ~128'h0 << (128 - 16 * int'(tbl[i].len));
      tbl[i].exp_err = CHK && tbl[i].crc_xor != 16'h0;
      tbl[i].exp_data = {tbl[i].vld, tbl[i].len, tbl[i].words & mask};
    end

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_data", data_to_fifo, 140'h0);
    chk("rst_wr", 140'(fifo_w_enable), 140'h0);
    chk("rst_err", 140'(crc_err), 140'h0);
    chk("rst_valid", 140'(crc_valid_o), 140'h0);
    rst_n = 1'b1;
    send(16'h1234);
    send(16'hFFFF);

    send_literal4(16'h1D0F, 1'b0, {8'h01, 4'h1, 128'h0});
    send_literal4(16'h1D0F, 1'b0, {8'h01, 4'h1, 128'h0});
    send_literal4(16'h1D0E, CHK, {8'h01, 4'h1, 128'h0});
    send(16'hE0E0); send(16'h0A00);
    send(16'hE0E0); send(16'h0109);
    send_literal4(16'h1D0F, 1'b0, {8'h01, 4'h1, 128'h0});

    for (int i = 0; i < 6; i++) send_frame(tbl[i]);

    send(16'h0000);
    send(16'hE0E0); send(16'h0108);
    send(16'h1111); send(16'h2222); send(16'h3333);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", data_to_fifo, 140'h0);
    chk("midrst_wr", 140'(fifo_w_enable), 140'h0);
    chk("midrst_err", 140'(crc_err), 140'h0);
    chk("midrst_valid", 140'(crc_valid_o), 140'h0);
    last_written = 140'h0;
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    send(16'h4444);
    send_literal4(16'h1D0F, 1'b0, {8'h01, 4'h1, 128'h0});

    send(16'h0000);
    repeat (10) @(posedge clk_in);
    #1;
    chk("scoreboard_drained", 140'(q.size()), 140'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
